// File: rtl/mdio_master_22_45_pkg.sv
// Shared types and field encodings for the MDIO station-management master.
package mdio_master_22_45_pkg;
  localparam logic [1:0] ST_C22      = 2'b01;
  localparam logic [1:0] ST_C45      = 2'b00;
  localparam logic [1:0] OP_ADDR     = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b11;
  localparam logic [1:0] OP_PRD_INC  = 2'b10;
  localparam logic [1:0] OP_C22_READ = 2'b10;

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_PRE       = 6'b000010,
    S_HDR       = 6'b000100,
    S_TA        = 6'b001000,
    S_DATA      = 6'b010000,
    S_IDLE_CELL = 6'b100000
  } state_e;

  // Frames where the PHY owns the bus from turnaround onwards.
  function automatic logic is_read(input logic c45, input logic [1:0] op);
    return c45 ? op[1] : (op == OP_C22_READ);
  endfunction
endpackage

// File: rtl/mdio_master_22_45_if.sv
// Request/response handshake between the register-access engine and the MDIO master.
interface mdio_master_22_45_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_c45;
  logic [1:0]  req_op;
  logic [4:0]  req_phyad;
  logic [4:0]  req_regad;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (output req_valid, req_c45, req_op, req_phyad, req_regad, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_c45, req_op, req_phyad, req_regad, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mdio_master_22_45_mdc_gen.sv
// MDC divider: each bit cell is a low half then a high half; ticks mark the edges.
module mdio_mdc_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk_25m,
  input  logic rst_n,
  input  logic active,
  input  logic clr,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = $clog2(CLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          mdc_q, mdc_d;

  // clr forces the cell phase back to zero so a new frame starts on a fresh low half.
  always_comb begin
    div_d = '0;
    mdc_d = 1'b0;
    if (active && !clr) begin
      div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
      mdc_d = (div_d >= DW'(HALF));
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc       = mdc_q;
  assign rise_tick = active && (div_q == DW'(HALF - 1));
  assign fall_tick = active && (div_q == DW'(CLK_DIV - 1));
endmodule

// File: rtl/mdio_master_22_45.sv
// MDIO master (Clause 22/45): one request serialised per frame, one response returned.
module mdio_master_22_45
  import mdio_master_22_45_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic                 clk_25m,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 opendrain_mode,
  input  logic                 pre_suppress,
  mdio_master_22_45_if.slave   req_if,
  output logic                 mdc,
  input  logic                 mdio_in,
  output logic                 mdio_out,
  output logic                 mdio_oe
);
  state_e      state_q, state_d, ns;
  logic [5:0]  bit_q, bit_d, nb;
  logic [13:0] hdr_q, hdr_d;
  logic [15:0] wdata_q, wdata_d, rd_q, rd_d, rsp_rdata_q, rsp_rdata_d;
  logic        ta_err_q, ta_err_d, out_q, out_d, oe_q, oe_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0]  sync_q, sync_d;
  logic        init_q;
  logic        fall_tick, rise_tick, last, accept, rd_now, ready;

  mdio_mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk_25m  (clk_25m),
    .rst_n    (rst_n),
    .active   (state_q != S_IDLE),
    .clr      (state_d == S_IDLE),
    .mdc      (mdc),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick)
  );

  // Ready drops for the response cycle so an acceptance never coincides with rsp_valid.
  assign ready  = enable && (state_q == S_IDLE) && !rsp_valid_q && init_q;
  assign accept = req_if.req_valid && ready;
  assign rd_now = is_read(~hdr_q[12], hdr_q[11:10]);
  assign sync_d = {sync_q[0], mdio_in};

  always_comb begin
    state_d = state_q;  bit_d = bit_q;  hdr_d = hdr_q;  wdata_d = wdata_q;
    rd_d = rd_q;  ta_err_d = ta_err_q;  out_d = out_q;  oe_d = oe_q;
    rsp_valid_d = 1'b0;  rsp_rdata_d = rsp_rdata_q;  rsp_err_d = rsp_err_q;
    last = 1'b0;  ns = state_q;  nb = '0;
    if (!enable) begin
      state_d = S_IDLE;  bit_d = '0;  out_d = 1'b1;  oe_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        state_d  = pre_suppress ? S_HDR : S_PRE;
        bit_d    = '0;
        hdr_d    = {req_if.req_c45 ? ST_C45 : ST_C22, req_if.req_op,
                    req_if.req_phyad, req_if.req_regad};
        wdata_d  = req_if.req_wdata;
        rd_d     = '0;
        ta_err_d = 1'b0;
        out_d    = ~pre_suppress;  // first ST bit is always 0
        oe_d     = 1'b1;
      end
    end else begin
      if (rise_tick) begin
        if (state_q == S_TA && bit_q == 6'd1) ta_err_d = sync_q[1];
        if (state_q == S_DATA) rd_d = {rd_q[14:0], sync_q[1]};
      end
      if (fall_tick) begin
        unique case (state_q)
          S_PRE:   begin last = (bit_q == 6'(PRE_LEN - 1)); ns = last ? S_HDR : S_PRE; end
          S_HDR:   begin last = (bit_q == 6'd13); ns = last ? S_TA : S_HDR; end
          S_TA:    begin last = (bit_q == 6'd1);  ns = last ? S_DATA : S_TA; end
          S_DATA:  begin last = (bit_q == 6'd15); ns = last ? S_IDLE_CELL : S_DATA; end
          default: begin last = 1'b1; ns = S_IDLE; end
        endcase
        nb      = last ? 6'd0 : bit_q + 6'd1;
        state_d = ns;
        bit_d   = nb;
        unique case (ns)
          S_PRE:   begin out_d = 1'b1; oe_d = 1'b1; end
          S_HDR:   begin out_d = hdr_q[4'd13 - nb[3:0]]; oe_d = 1'b1; end
          S_TA:    begin out_d = rd_now | ~nb[0]; oe_d = ~rd_now; end
          S_DATA:  begin out_d = rd_now | wdata_q[4'd15 - nb[3:0]]; oe_d = ~rd_now; end
          default: begin out_d = 1'b1; oe_d = 1'b0; end
        endcase
        if (ns == S_IDLE) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_now ? rd_q : 16'h0000;
          rsp_err_d   = rd_now & ta_err_q;
        end
      end
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  bit_q <= '0;  hdr_q <= '0;  wdata_q <= '0;
      rd_q <= '0;  ta_err_q <= 1'b0;  out_q <= 1'b1;  oe_q <= 1'b0;
      rsp_valid_q <= 1'b0;  rsp_rdata_q <= '0;  rsp_err_q <= 1'b0;
      sync_q <= 2'b11;  init_q <= 1'b0;
    end else begin
      state_q <= state_d;  bit_q <= bit_d;  hdr_q <= hdr_d;  wdata_q <= wdata_d;
      rd_q <= rd_d;  ta_err_q <= ta_err_d;  out_q <= out_d;  oe_q <= oe_d;
      rsp_valid_q <= rsp_valid_d;  rsp_rdata_q <= rsp_rdata_d;  rsp_err_q <= rsp_err_d;
      sync_q <= sync_d;  init_q <= 1'b1;
    end
  end

  assign req_if.req_ready = ready;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign mdio_out         = out_q;
  assign mdio_oe          = opendrain_mode ? (oe_q & ~out_q) : oe_q;
endmodule

// File: tb/tb_mdio_master_22_45.sv
// Bench for mdio_master_22_45: PHY responder on the bus, frame-level reference model.
module tb_mdio_master_22_45;
  localparam int CLK_DIV = 10;
  localparam int PRE     = 32;

  logic clk_25m = 1'b0;
  logic rst_n, enable, opendrain_mode, pre_suppress;
  logic mdc, mdio_in, mdio_out, mdio_oe, mdio_bus;
  logic phy_oe, phy_out, slv_clr;
  int   vectors = 0, miscompares = 0, rsp_cnt = 0;

  mdio_master_22_45_if req_if ();

  mdio_master_22_45 #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE)) dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .enable(enable), .opendrain_mode(opendrain_mode),
    .pre_suppress(pre_suppress), .req_if(req_if), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe));

  always #20 clk_25m = ~clk_25m;

  // Pull-up bus shared by master and bench PHY.
  assign mdio_bus = mdio_oe ? mdio_out : (phy_oe ? phy_out : 1'b1);
  assign mdio_in  = mdio_bus;

  always @(posedge clk_25m) if (req_if.rsp_valid) rsp_cnt++;

  function automatic logic [15:0] c22_val(input logic [4:0] ra);
    return (ra == 5'd2) ? 16'hA5C3 : {ra, 11'h2B6};
  endfunction
  function automatic logic [15:0] c45_val(input logic [4:0] dev, input logic [15:0] a);
    return a ^ {dev, 11'h1A5};
  endfunction

  // Bench PHY at address 3: decodes frames on MDC rise, drives on MDC fall.
  logic [15:0]  c45_addr [32] = '{default: '0};
  logic [13:0]  s_hdr;
  logic [15:0]  s_data, s_wr;
  logic         s_hit, s_c45, s_rd;
  int           s_pos, obs_n;
  logic [127:0] obs_bits, obs_oe;

  always @(posedge mdc or negedge mdc or posedge slv_clr) begin
    if (slv_clr) begin
      s_pos = -1; s_hit = 1'b0; phy_oe = 1'b0; phy_out = 1'b1;
      obs_bits = '0; obs_oe = '0; obs_n = 0;
    end else if (mdc) begin
      obs_bits = {obs_bits[126:0], mdio_bus};
      obs_oe   = {obs_oe[126:0], mdio_oe};
      obs_n++;
      if (s_pos < 0) begin
        if (!mdio_bus) begin s_hdr = '0; s_pos = 1; end
      end else begin
        if (s_pos < 14) s_hdr = {s_hdr[12:0], mdio_bus};
        else if (s_pos >= 16) s_wr = {s_wr[14:0], mdio_bus};
        s_pos++;
        if (s_pos == 14) begin
          s_c45 = (s_hdr[13:12] == 2'b00);
          s_rd  = s_c45 ? s_hdr[11] : (s_hdr[11:10] == 2'b10);
          s_hit = s_rd && (s_hdr[9:5] == 5'd3);
          if (s_hit) begin
            s_data = s_c45 ? c45_val(s_hdr[4:0], c45_addr[s_hdr[4:0]]) : c22_val(s_hdr[4:0]);
            if (s_c45 && s_hdr[11:10] == 2'b10) c45_addr[s_hdr[4:0]] = c45_addr[s_hdr[4:0]] + 16'd1;
          end
        end
        if (s_pos == 32) begin
          if (s_hdr[13:10] == 4'b0000 && s_hdr[9:5] == 5'd3) c45_addr[s_hdr[4:0]] = s_wr;
          s_pos = -1; s_hit = 1'b0;
        end
      end
    end else begin
      phy_oe = 1'b0; phy_out = 1'b1;
      if (s_hit && s_pos == 15) begin phy_oe = 1'b1; phy_out = 1'b0; end
      else if (s_hit && s_pos >= 16 && s_pos < 32) begin phy_oe = 1'b1; phy_out = s_data[31-s_pos]; end
    end
  end

  logic [15:0] exp_addr [32];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected bus bits and master output enables per cell, plus the response.
  task automatic model_frame(input logic c45, input logic [1:0] op, input logic [4:0] phy, ra,
                             input logic [15:0] wd, input logic ps, od,
                             output logic [127:0] eb, eo, output int n,
                             output logic [15:0] erd, output logic eerr);
    logic bq[$];
    logic rd, hit, drove;
    logic [15:0] dv;
    logic [1:0] st;
    int hdr_end;
    st  = c45 ? 2'b00 : 2'b01;
    rd  = c45 ? op[1] : (op == 2'b10);
    hit = (phy == 5'd3);
    dv  = wd;
    if (rd) dv = !hit ? 16'hFFFF : (c45 ? c45_val(ra, exp_addr[ra]) : c22_val(ra));
    if (rd && hit && c45 && op == 2'b10) exp_addr[ra] = exp_addr[ra] + 16'd1;
    if (!rd && hit && c45 && op == 2'b00) exp_addr[ra] = wd;
    if (!ps) for (int i = 0; i < PRE; i++) bq.push_back(1'b1);
    hdr_end = bq.size() + 14;
    for (int i = 1; i >= 0; i--) bq.push_back(st[i]);
    for (int i = 1; i >= 0; i--) bq.push_back(op[i]);
    for (int i = 4; i >= 0; i--) bq.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) bq.push_back(ra[i]);
    bq.push_back(1'b1);
    bq.push_back(rd && !hit);
    for (int i = 15; i >= 0; i--) bq.push_back(dv[i]);
    bq.push_back(1'b1);
    n = bq.size(); eb = '0; eo = '0;
    for (int i = 0; i < n; i++) begin
      drove = (i < hdr_end) || (!rd && i < n - 1);
      eb = {eb[126:0], bq[i]};
      eo = {eo[126:0], drove && (!od || !bq[i])};
    end
    erd  = rd ? dv : 16'h0000;
    eerr = rd && !hit;
  endtask

  task automatic issue(input logic c45, input logic [1:0] op, input logic [4:0] phy, ra,
                       input logic [15:0] wd);
    int k = 0;
    while (!req_if.req_ready && k < 200) begin @(negedge clk_25m); k++; end
    chk("ready_before_req", req_if.req_ready, 1);
    req_if.req_c45 = c45; req_if.req_op = op; req_if.req_phyad = phy;
    req_if.req_regad = ra; req_if.req_wdata = wd; req_if.req_valid = 1'b1;
    @(posedge clk_25m);
    @(negedge clk_25m);
    req_if.req_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic c45, input logic [1:0] op,
                           input logic [4:0] phy, ra, input logic [15:0] wd, input logic ps, od);
    logic [127:0] eb, eo;
    logic [15:0]  erd;
    logic         eerr;
    int n, lat, elat, rc0;
    model_frame(c45, op, phy, ra, wd, ps, od, eb, eo, n, erd, eerr);
    pre_suppress = ps; opendrain_mode = od;
    slv_clr = 1'b1; #1; slv_clr = 1'b0;
    @(negedge clk_25m);
    rc0 = rsp_cnt;
    issue(c45, op, phy, ra, wd);
    lat = 1;
    chk({tag, " busy_ready"}, req_if.req_ready, 0);
    // A competing request while busy must be ignored.
    req_if.req_valid = 1'b1; req_if.req_op = ~op; req_if.req_wdata = ~wd; req_if.req_phyad = ~phy;
    while (!req_if.rsp_valid && lat < 5000) begin
      @(negedge clk_25m); lat++;
      if (lat == 40) req_if.req_valid = 1'b0;
    end
    elat = n * CLK_DIV;
    chk({tag, " latency"}, (lat >= elat - 1 && lat <= elat + 1) ? elat : lat, elat);
    chk({tag, " rdata"}, req_if.rsp_rdata, erd);
    chk({tag, " err"}, req_if.rsp_err, eerr);
    chk({tag, " ready_at_rsp"}, req_if.req_ready, 0);
    chk({tag, " cells"}, obs_n, n);
    chk({tag, " bits"}, obs_bits, eb);
    chk({tag, " oe"}, obs_oe, eo);
    @(negedge clk_25m);
    chk({tag, " after_rsp"}, {req_if.rsp_valid, req_if.req_ready, mdc, mdio_oe}, 4'b0100);
    chk({tag, " rsp_count"}, rsp_cnt - rc0, 1);
  endtask

  initial begin
    int rc0;
    foreach (exp_addr[i]) exp_addr[i] = '0;
    rst_n = 1'b0; enable = 1'b1; opendrain_mode = 1'b0; pre_suppress = 1'b0;
    slv_clr = 1'b1;
    req_if.req_valid = 1'b0; req_if.req_c45 = 1'b0; req_if.req_op = '0;
    req_if.req_phyad = '0; req_if.req_regad = '0; req_if.req_wdata = '0;
    repeat (3) @(negedge clk_25m);
    chk("reset_outputs", {mdc, mdio_out, mdio_oe, req_if.req_ready, req_if.rsp_valid,
                          req_if.rsp_rdata, req_if.rsp_err}, {5'b01000, 16'h0000, 1'b0});
    slv_clr = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk_25m);
    chk("idle_mdc_low", {mdc, mdio_oe}, 2'b00);

    run_frame("c22_wr", 1'b0, 2'b01, 5'h03, 5'h00, 16'h1140, 1'b0, 1'b0);
    chk("c22_wr literal", obs_bits[32:1], 32'h5182_1140);
    chk("c22_wr preamble", obs_bits[64:33], 32'hFFFF_FFFF);
    run_frame("c22_rd", 1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 1'b0);
    chk("c22_rd literal", req_if.rsp_rdata, 16'hA5C3);
    run_frame("c22_nophy", 1'b0, 2'b10, 5'h1F, 5'h02, 16'h0000, 1'b0, 1'b0);
    run_frame("c45_addr", 1'b1, 2'b00, 5'h03, 5'h01, 16'h0002, 1'b0, 1'b0);
    run_frame("c45_rd", 1'b1, 2'b11, 5'h03, 5'h01, 16'h0000, 1'b0, 1'b0);
    run_frame("c45_prd", 1'b1, 2'b10, 5'h03, 5'h01, 16'h0000, 1'b0, 1'b0);
    run_frame("c45_rd2", 1'b1, 2'b11, 5'h03, 5'h01, 16'h0000, 1'b0, 1'b0);
    run_frame("ps_od_wr", 1'b0, 2'b01, 5'h03, 5'h04, 16'h8421, 1'b1, 1'b1);

    // Abort in the high half of header bit 7.
    pre_suppress = 1'b1; opendrain_mode = 1'b0;
    slv_clr = 1'b1; #1; slv_clr = 1'b0;
    @(negedge clk_25m);
    rc0 = rsp_cnt;
    issue(1'b0, 2'b01, 5'h03, 5'h1F, 16'hFFFF);
    repeat (7 * CLK_DIV + CLK_DIV / 2 + 1) @(negedge clk_25m);
    chk("abort pre_state", {mdc, mdio_oe}, 2'b11);
    enable = 1'b0;
    @(negedge clk_25m);
    chk("abort next_cycle", {mdc, mdio_oe, req_if.req_ready}, 3'b000);
    repeat (4) @(negedge clk_25m);
    enable = 1'b1;
    repeat (800) @(negedge clk_25m);
    chk("abort no_rsp", rsp_cnt - rc0, 0);
    chk("abort idle", {mdc, mdio_oe, req_if.req_ready}, 3'b001);
    run_frame("post_abort", 1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    issue(1'b0, 2'b01, 5'h03, 5'h07, 16'h0F0F);
    repeat (200) @(negedge clk_25m);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset", {mdc, mdio_out, mdio_oe, req_if.req_ready, req_if.rsp_valid,
                           req_if.rsp_rdata, req_if.rsp_err}, {5'b01000, 16'h0000, 1'b0});
    @(negedge clk_25m);
    rst_n = 1'b1;
    run_frame("post_reset", 1'b0, 2'b01, 5'h03, 5'h05, 16'h3C5A, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic        c45, ps, od;
      logic [1:0]  op;
      logic [4:0]  phy, ra;
      logic [15:0] wd;
      c45 = 1'($urandom); ps = 1'($urandom); od = 1'($urandom);
      op  = 2'($urandom); ra = 5'($urandom % 4); wd = 16'($urandom);
      phy = ($urandom % 3 != 0) ? 5'h03 : 5'($urandom);
      run_frame($sformatf("rand%0d", i), c45, op, phy, ra, wd, ps, od);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
